sram_wb_arbiter: RTL and testbench

// - Shares SRAM macro port 0 (rw, synchronous) between two Wishbone classic masters (m0, m1).
// - Sits between the interconnect slave slots and sram_wrapper. Replaces the zero-latency
//   stb-as-ack path with a sequenced access whose ack is returned only after read data is captured.
// - Round-robin arbitration. One access in flight at a time.

---
 rtl/sram_wb_arbiter_pkg.sv | 13 +
 rtl/sram_rr_arbiter.sv | 31 +++
 rtl/sram_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_wb_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_wb_arbiter_pkg.sv
// Shared types for the SRAM Wishbone arbiter: FSM state encoding and the default byte-lane offset.
package sram_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam int ADDR_LSB_DEFAULT = 2;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant index, registered last_grant updated on accept.
module sram_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt
);

    logic last_grant;

    // On contention the master that did not win last time is served.
    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant;
            default: gnt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Sequences two Wishbone classic masters onto SRAM port 0 (IDLE->ISSUE->WAIT->ACK), one access at a time.
// Optional SRAM_ARB_ERR_EN: misaligned requests skip the SRAM and return m*_err instead of m*_ack.
module sram_wb_arbiter
    import sram_wb_arbiter_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int ADDR_LSB = ADDR_LSB_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [31:0]   m0_adr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
`ifdef SRAM_ARB_ERR_EN
    output logic          m0_err,
`endif
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [31:0]   m1_adr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
`ifdef SRAM_ARB_ERR_EN
    output logic          m1_err,
`endif
    output logic          sram_csb0,
    output logic          sram_web0,
    output logic [AW-1:0] sram_addr0,
    output logic [DW-1:0] sram_din0,
    input  logic [DW-1:0] sram_dout0,
    output logic          busy
);

    arb_state_t    state, state_d;
    logic [1:0]    req;
    logic          gnt;
    logic          grant_q;
    logic          we_q;
    logic          err_q;
    logic          misaligned;
    logic [DW-1:0] rdata_q;
    logic [31:0]   sel_adr;
    logic          sel_we;
    logic [DW-1:0] sel_wdata;
    logic          accept;

    assign req       = {m1_cyc & m1_stb, m0_cyc & m0_stb};
    assign accept    = (state == ST_IDLE) && (|req);
    assign sel_adr   = gnt ? m1_adr   : m0_adr;
    assign sel_we    = gnt ? m1_we    : m0_we;
    assign sel_wdata = gnt ? m1_wdata : m0_wdata;

`ifdef SRAM_ARB_ERR_EN
    assign misaligned = |sel_adr[ADDR_LSB-1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Bits outside the word index are intentionally ignored.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, sel_adr[31:ADDR_LSB+AW], sel_adr[ADDR_LSB-1:0]};

    sram_rr_arbiter u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (accept),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
`ifdef SRAM_ARB_ERR_EN
        m0_err  = 1'b0;
        m1_err  = 1'b0;
`endif
        case (state)
            ST_IDLE:  if (|req) state_d = misaligned ? ST_ACK : ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_ACK;
            ST_ACK: begin
                state_d = ST_IDLE;
                // A master that dropped cyc/stb mid-access gets no response.
                m0_ack  = ~err_q & ~grant_q & req[0];
                m1_ack  = ~err_q &  grant_q & req[1];
`ifdef SRAM_ARB_ERR_EN
                m0_err  =  err_q & ~grant_q & req[0];
                m1_err  =  err_q &  grant_q & req[1];
`endif
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture on accept; SRAM strobes are registered so the macro sees clean levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            rdata_q    <= '0;
        end else begin
            sram_csb0 <= 1'b1;
            sram_web0 <= 1'b1;
            if (accept) begin
                grant_q    <= gnt;
                we_q       <= sel_we;
                err_q      <= misaligned;
                sram_addr0 <= sel_adr[ADDR_LSB+AW-1:ADDR_LSB];
                sram_din0  <= sel_wdata;
            end
            if (state_d == ST_ISSUE) begin
                sram_csb0 <= 1'b0;
                sram_web0 <= ~sel_we;
            end
            if (state == ST_WAIT && !we_q) begin
                rdata_q <= sram_dout0;
            end
        end
    end

    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Bench for sram_wb_arbiter: directed vector table, corner sequences and randomized traffic vs a transaction model.
module tb_sram_wb_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [31:0]   m0_adr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack;
    logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [31:0]   m1_adr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack;
`ifdef SRAM_ARB_ERR_EN
    logic          m0_err, m1_err;
`endif
    logic          sram_csb0, sram_web0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_wb_arbiter #(.AW(AW), .DW(DW), .ADDR_LSB(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_cyc     (m0_cyc),
        .m0_stb     (m0_stb),
        .m0_we      (m0_we),
        .m0_adr     (m0_adr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m0_ack     (m0_ack),
`ifdef SRAM_ARB_ERR_EN
        .m0_err     (m0_err),
`endif
        .m1_cyc     (m1_cyc),
        .m1_stb     (m1_stb),
        .m1_we      (m1_we),
        .m1_adr     (m1_adr),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .m1_ack     (m1_ack),
`ifdef SRAM_ARB_ERR_EN
        .m1_err     (m1_err),
`endif
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0),
        .busy       (busy)
    );

    // Behavioural single-port synchronous SRAM macro
    logic [DW-1:0] smem [256];
    initial for (int i = 0; i < 256; i++) smem[i] = '0;
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) smem[sram_addr0] <= sram_din0;
            else            sram_dout0 <= smem[sram_addr0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted access occupies the port for four clocks and
    // is answered in the last of them; memory effect and read-back follow the macro timing.
    int            age = 0;
    int            mg = 0;
    int            last = 1;
    bit            mwe = 1'b0;
    int            maddr = 0;
    logic [31:0]   mwd = '0;
    logic [31:0]   rexp = '0;
    logic [31:0]   mmem [256];
    bit            mr0, mr1;
    bit            exp_ack0 = 1'b0, exp_ack1 = 1'b0;
    bit            chk_en = 1'b1;

    initial for (int i = 0; i < 256; i++) mmem[i] = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            age = 0; last = 1; rexp = '0;
        end else if (age == 0) begin
            mr0 = m0_cyc && m0_stb;
            mr1 = m1_cyc && m1_stb;
            if (mr0 || mr1) begin
                mg    = (mr0 && mr1) ? ((last == 0) ? 1 : 0) : (mr1 ? 1 : 0);
                last  = mg;
                mwe   = (mg == 1) ? m1_we : m0_we;
                maddr = int'((((mg == 1) ? m1_adr : m0_adr) >> 2) & 32'hFF);
                mwd   = (mg == 1) ? m1_wdata : m0_wdata;
                age   = 1;
            end
        end else if (age == 1) begin
            if (mwe) mmem[maddr] = mwd;
            age = 2;
        end else if (age == 2) begin
            if (!mwe) rexp = mmem[maddr];
            age = 3;
        end else begin
            age = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_ack0 = (age == 3) && (mg == 0) && m0_cyc && m0_stb;
            exp_ack1 = (age == 3) && (mg == 1) && m1_cyc && m1_stb;
            chk("busy",     32'(busy),      32'(age != 0));
            chk("csb0",     32'(sram_csb0), 32'(age != 1));
            chk("m0_ack",   32'(m0_ack),    32'(exp_ack0));
            chk("m1_ack",   32'(m1_ack),    32'(exp_ack1));
            chk("m0_rdata", m0_rdata, rexp);
            chk("m1_rdata", m1_rdata, rexp);
            if (age == 1) begin
                chk("web0",  32'(sram_web0),  32'(!mwe));
                chk("addr0", 32'(sram_addr0), 32'(maddr));
                chk("din0",  sram_din0, mwd);
            end
        end
    end

    typedef struct {
        bit          r0, r1, we0, we1;
        logic [31:0] a0, a1, d0, d1;
        int          first;
        logic [7:0]  exp_addr;
        logic [31:0] exp_rd0, exp_rd1;
    } vec_t;

    vec_t vecs[6];

    task automatic set_m(input int m, input bit cyc, input bit stb, input bit we,
                         input logic [31:0] adr, input logic [31:0] wd);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdata = wd;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdata = wd;
        end
    endtask

    task automatic rand_req(input int m);
        set_m(m, 1'b1, 1'b1, 1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FC3C, $urandom);
    endtask

    task automatic rand_idle(input int m);
        set_m(m, 1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom, $urandom);
    endtask

    // Wait up to limit cycles for an ack on master m; returns cycle index or 0.
    task automatic wait_ack(input int m, input int limit, output int lat);
        lat = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk); #1;
            if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int t0, t1, n0, n1, lat;
        bit lowcs;

        vecs[0] = '{r0:1, r1:1, we0:0, we1:0, a0:32'h10, a1:32'h20, d0:0, d1:0,
                    first:0, exp_addr:8'h04, exp_rd0:32'h0, exp_rd1:32'h0};
        vecs[1] = '{r0:0, r1:1, we0:0, we1:1, a0:32'h0, a1:32'hFFFF_FC20, d0:0, d1:32'hCAFE_F00D,
                    first:1, exp_addr:8'h08, exp_rd0:32'h0, exp_rd1:32'h0};
        vecs[2] = '{r0:1, r1:0, we0:1, we1:0, a0:32'h10, a1:32'h0, d0:32'hDEAD_BEEF, d1:0,
                    first:0, exp_addr:8'h04, exp_rd0:32'h0, exp_rd1:32'h0};
        vecs[3] = '{r0:1, r1:1, we0:0, we1:0, a0:32'h10, a1:32'h20, d0:0, d1:0,
                    first:1, exp_addr:8'h08, exp_rd0:32'hDEAD_BEEF, exp_rd1:32'hCAFE_F00D};
        vecs[4] = '{r0:1, r1:1, we0:0, we1:0, a0:32'h20, a1:32'h10, d0:0, d1:0,
                    first:1, exp_addr:8'h04, exp_rd0:32'hCAFE_F00D, exp_rd1:32'hDEAD_BEEF};
        vecs[5] = '{r0:1, r1:0, we0:0, we1:0, a0:32'h10, a1:32'h0, d0:0, d1:0,
                    first:0, exp_addr:8'h04, exp_rd0:32'hDEAD_BEEF, exp_rd1:32'h0};

        repeat (2) @(negedge clk);
        chk("rst_csb0",  32'(sram_csb0),  32'd1);
        chk("rst_web0",  32'(sram_web0),  32'd1);
        chk("rst_addr0", 32'(sram_addr0), 32'd0);
        chk("rst_din0",  sram_din0, 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_rdata", m0_rdata, 32'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            set_m(0, vecs[i].r0, vecs[i].r0, vecs[i].we0, vecs[i].a0, vecs[i].d0);
            set_m(1, vecs[i].r1, vecs[i].r1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
            t0 = 0; t1 = 0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk); #1;
                if (c == 1) begin
                    chk("vec_csb0",  32'(sram_csb0),  32'd0);
                    chk("vec_addr0", 32'(sram_addr0), 32'(vecs[i].exp_addr));
                    chk("vec_web0",  32'(sram_web0),
                        32'(!((vecs[i].first == 1) ? vecs[i].we1 : vecs[i].we0)));
                end
                if (m0_ack && t0 == 0) begin
                    t0 = c;
                    if (!vecs[i].we0) chk("vec_rd0", m0_rdata, vecs[i].exp_rd0);
                    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                end
                if (m1_ack && t1 == 0) begin
                    t1 = c;
                    if (!vecs[i].we1) chk("vec_rd1", m1_rdata, vecs[i].exp_rd1);
                    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                end
                if ((t0 != 0 || !vecs[i].r0) && (t1 != 0 || !vecs[i].r1)) break;
            end
            if (vecs[i].r0) chk("vec_lat0", 32'(t0), (vecs[i].first == 0) ? 32'd3 : 32'd7);
            if (vecs[i].r1) chk("vec_lat1", 32'(t1), (vecs[i].first == 1) ? 32'd3 : 32'd7);
        end

        // m1 held requesting, m0 idle: one ack per four clocks
        @(negedge clk); #1;
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        n0 = 0; n1 = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); #1;
            if (m1_ack) n1++;
            if (m0_ack) n0++;
        end
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("b2b_m1_acks", 32'(n1), 32'd4);
        chk("b2b_m0_acks", 32'(n0), 32'd0);
        repeat (2) @(negedge clk);

        // m0 aborts during WAIT
        #1 set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        repeat (2) @(negedge clk);
        #1 set_m(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk); #1;
        chk("abort_ack",  32'(m0_ack), 32'd0);
        chk("abort_busy", 32'(busy),   32'd1);
        @(negedge clk); #1;
        chk("abort_idle", 32'(busy),   32'd0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        wait_ack(1, 8, lat);
        chk("abort_next_lat", 32'(lat), 32'd3);
        chk("abort_next_rd",  m1_rdata, 32'hCAFE_F00D);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset pulse while the access is in ISSUE
        #1 set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk); #1;
        chk("rst_mid_issue", 32'(sram_csb0), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_csb0", 32'(sram_csb0), 32'd1);
        chk("rst_mid_busy", 32'(busy),      32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_ack(0, 8, lat);
        chk("rst_after_lat", 32'(lat), 32'd3);
        chk("rst_after_rd",  m0_rdata, 32'hDEAD_BEEF);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Randomized traffic, checked every cycle by the model
        for (int k = 0; k < 800; k++) begin
            @(negedge clk); #1;
            if (m0_cyc) begin
                if (exp_ack0) begin
                    if ($urandom_range(1, 0) == 1) rand_req(0);
                    else rand_idle(0);
                end
            end else if ($urandom_range(3, 0) == 0) rand_req(0);
            else rand_idle(0);
            if (m1_cyc) begin
                if (exp_ack1) begin
                    if ($urandom_range(1, 0) == 1) rand_req(1);
                    else rand_idle(1);
                end
            end else if ($urandom_range(3, 0) == 0) rand_req(1);
            else rand_idle(1);
        end
        #1 set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) @(negedge clk);

`ifdef SRAM_ARB_ERR_EN
        // Misaligned m1 read: error response without touching the SRAM
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h13, 32'h0);
        lowcs = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            if (!sram_csb0) lowcs = 1'b1;
            if (c == 1) begin
                chk("err_m1_err", 32'(m1_err), 32'd1);
                chk("err_m1_ack", 32'(m1_ack), 32'd0);
                set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                chk("err_m1_err_one", 32'(m1_err), 32'd0);
            end
        end
        chk("err_csb0_never_low", 32'(lowcs), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
